// File: rtl/alu4_result_fifo_pkg.sv
// alu4_result_fifo_pkg: opcodes, flag indices, entry layout and occupancy states shared with alu4
package alu4_result_fifo_pkg;
  localparam logic [2:0] OP_NOTA = 3'b000;
  localparam logic [2:0] OP_NOTB = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_ADD  = 3'b110;
  localparam logic [2:0] OP_SUB  = 3'b111;
  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;
  localparam int ENTRY_W = 11;
  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    PARTIAL = 2'b01,
    FULL    = 2'b10
  } occ_t;
  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [2:0] op, input logic [3:0] res,
                                                    input logic c, input logic n, input logic z,
                                                    input logic v);
    logic [3:0] f;
    f = '0;
    f[FLAG_C] = c;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_V] = v;
    return {op, res, f};
  endfunction
endpackage

// File: rtl/alu4_fifo_mem.sv
// alu4_fifo_mem: unreset register array, synchronous write, asynchronous read
module alu4_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int AW = 2,
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/alu4_result_fifo.sv
// alu4_result_fifo: show-ahead result FIFO for alu4 with sticky overflow and drop counter
module alu4_result_fifo
  import alu4_result_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [3:0]    in_result,
  input  logic          in_c,
  input  logic          in_n,
  input  logic          in_z,
  input  logic          in_v,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    out_op,
  output logic [3:0]    out_result,
  output logic [3:0]    out_flags,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          sticky_v,
  input  logic          sticky_clr,
  output logic [3:0]    drop_cnt,
  input  logic          drop_clr
);
  localparam int CW = AW + 1;
  occ_t state, state_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop, drop_inc, sticky_set;
  logic [ENTRY_W-1:0] rdata;
  assign full      = state == FULL;
  assign empty     = state == EMPTY;
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign drop_inc  = in_valid & full;
  assign sticky_set = push & in_v & (in_op == OP_ADD || in_op == OP_SUB);
  assign {out_op, out_result, out_flags} = rdata;
  always_comb
    state_nxt = (state == EMPTY) ? (push ? PARTIAL : EMPTY)
              : (state == FULL)  ? (pop ? PARTIAL : FULL)
              : (push && !pop && count == CW'(DEPTH - 1)) ? FULL
              : (pop && !push && count == CW'(1)) ? EMPTY : PARTIAL;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= EMPTY;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      sticky_v <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wr_ptr   <= wr_ptr + AW'(push);
      rd_ptr   <= rd_ptr + AW'(pop);
      count    <= count + CW'(push) - CW'(pop);
      sticky_v <= sticky_set | (sticky_v & ~sticky_clr);
      // a clear in the same cycle as a refused push leaves exactly one drop counted
      drop_cnt <= drop_clr ? {3'b000, drop_inc} : drop_cnt + {3'b000, drop_inc & ~&drop_cnt};
    end
  end
  alu4_fifo_mem #(.DEPTH(DEPTH), .AW(AW), .W(ENTRY_W)) u_mem (
    .clk   (clk),
    .we    (push & reset_n),
    .waddr (wr_ptr),
    .wdata (pack_entry(in_op, in_result, in_c, in_n, in_z, in_v)),
    .raddr (rd_ptr),
    .rdata (rdata)
  );
endmodule

// File: tb/tb_alu4_result_fifo.sv
// tb_alu4_result_fifo: directed plus random stimulus checked against a queue-based reference model
module tb_alu4_result_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n, in_valid, in_ready, in_c, in_n, in_z, in_v;
  logic out_valid, out_ready, full, empty, sticky_v, sticky_clr, drop_clr;
  logic [2:0] in_op, out_op;
  logic [3:0] in_result, out_result, out_flags, drop_cnt;
  logic [2:0] count;
  logic [10:0] q[$];
  logic m_sticky;
  logic [3:0] m_drop;
  int n_assert = 0, n_fail = 0;
  alu4_result_fifo #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_result(in_result), .in_c(in_c), .in_n(in_n), .in_z(in_z), .in_v(in_v),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_result(out_result),
    .out_flags(out_flags), .count(count), .full(full), .empty(empty), .sticky_v(sticky_v),
    .sticky_clr(sticky_clr), .drop_cnt(drop_cnt), .drop_clr(drop_clr)
  );
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] res,
                       input logic [3:0] fl, input logic rdy);
    in_valid = v; in_op = op; in_result = res;
    {in_c, in_n, in_z, in_v} = fl;
    out_ready = rdy;
  endtask
  task automatic model_edge();
    bit fm, ps, pp, inc;
    if (!reset_n) begin
      q.delete(); m_sticky = 1'b0; m_drop = 4'd0;
      return;
    end
    fm  = q.size() == 4;
    ps  = in_valid && !fm;
    pp  = out_ready && q.size() > 0;
    inc = in_valid && fm;
    if (drop_clr) m_drop = inc ? 4'd1 : 4'd0;
    else if (inc && m_drop != 4'd15) m_drop = m_drop + 4'd1;
    m_sticky = (ps && in_v && in_op >= 3'd6) || (m_sticky && !sticky_clr);
    if (pp) void'(q.pop_front());
    if (ps) q.push_back({in_op, in_result, in_c, in_n, in_z, in_v});
  endtask
  task automatic check_all();
    chk("count", 16'(count), 16'(q.size()));
    chk("empty", 16'(empty), 16'(q.size() == 0));
    chk("full", 16'(full), 16'(q.size() == 4));
    chk("in_ready", 16'(in_ready), 16'(q.size() != 4));
    chk("out_valid", 16'(out_valid), 16'(q.size() != 0));
    chk("sticky_v", 16'(sticky_v), 16'(m_sticky));
    chk("drop_cnt", 16'(drop_cnt), 16'(m_drop));
    if (q.size() > 0) chk("head", 16'({out_op, out_result, out_flags}), 16'(q[0]));
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask
  initial begin
    reset_n = 1'b0; sticky_clr = 1'b0; drop_clr = 1'b0;
    drive(0, 3'd0, 4'd0, 4'd0, 0);
    q.delete(); m_sticky = 1'b0; m_drop = 4'd0;
    #1;
    tick();
    reset_n = 1'b1;
    tick();
    chk("rst_empty", 16'(empty), 16'd1);
    chk("rst_in_ready", 16'(in_ready), 16'd1);
    chk("rst_drop", 16'(drop_cnt), 16'd0);
    // single ADD with v=1 into empty FIFO
    drive(1, 3'b110, 4'h9, 4'b0101, 0);
    tick();
    drive(0, 3'd0, 4'd0, 4'd0, 0);
    chk("t2_valid", 16'(out_valid), 16'd1);
    chk("t2_op", 16'(out_op), 16'h6);
    chk("t2_res", 16'(out_result), 16'h9);
    chk("t2_flags", 16'(out_flags), 16'h5);
    chk("t2_sticky", 16'(sticky_v), 16'd1);
    out_ready = 1; sticky_clr = 1;
    tick();
    out_ready = 0; sticky_clr = 0;
    // fill, overflow, drain
    for (int i = 1; i <= 4; i++) begin
      drive(1, 3'b011, 4'(i), 4'(i), 0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'b011, 4'hE, 4'd0, 0);
      tick();
    end
    chk("t3_full", 16'(full), 16'd1);
    chk("t3_in_ready", 16'(in_ready), 16'd0);
    chk("t3_drop", 16'(drop_cnt), 16'd3);
    for (int i = 1; i <= 4; i++) begin
      drive(0, 3'd0, 4'd0, 4'd0, 1);
      chk("t3_order", 16'(out_result), 16'(i));
      tick();
    end
    chk("t3_empty", 16'(empty), 16'd1);
    out_ready = 0; drop_clr = 1;
    tick();
    drop_clr = 0;
    // steady push+pop at count 2, pointers wrap
    for (int i = 0; i < 2; i++) begin
      drive(1, 3'b100, 4'(10 + i), 4'd0, 0);
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1, 3'b100, 4'(12 + i), 4'd0, 1);
      chk("t4_head", 16'(out_result), 16'(10 + i));
      tick();
      chk("t4_count", 16'(count), 16'd2);
    end
    drive(0, 3'd0, 4'd0, 4'd0, 1);
    tick(); tick();
    // sticky ignores logic ops; set wins over clear
    drive(1, 3'b010, 4'd1, 4'b0001, 0);
    tick();
    chk("t5_logic_v", 16'(sticky_v), 16'd0);
    drive(1, 3'b111, 4'd2, 4'b0001, 0); sticky_clr = 1;
    tick();
    sticky_clr = 0;
    chk("t5_set_wins", 16'(sticky_v), 16'd1);
    drive(1, 3'b001, 4'd3, 4'b0000, 0);
    tick();
    chk("t6_pre", 16'(count), 16'd3);
    // reset with push and pop in flight
    drive(1, 3'b110, 4'd7, 4'b0001, 1); reset_n = 0;
    tick();
    reset_n = 1; drive(0, 3'd0, 4'd0, 4'd0, 0);
    chk("t6_count", 16'(count), 16'd0);
    chk("t6_sticky", 16'(sticky_v), 16'd0);
    tick();
    chk("t6_empty", 16'(empty), 16'd1);
    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 99) < 65), 3'($urandom), 4'($urandom), 4'($urandom),
            1'($urandom_range(0, 99) < (i < 300 ? 35 : 70)));
      sticky_clr = $urandom_range(0, 19) == 0;
      drop_clr   = $urandom_range(0, 39) == 0;
      reset_n    = $urandom_range(0, 99) != 0;
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
